// File: rtl/net_iter_monitor.sv
// net_iter_monitor: consumes the en00..en10 stage strobes, counts network iterations and stops the
// network on convergence, timeout or sequence error. Define NET_ITER_SEQCHK_EN for full strobe order checking.
module net_iter_monitor #(
    parameter int DW       = 16,
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 1000,
    parameter int TOL      = 4,
    parameter int STABLE_N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [10:0]          en_bus,
    input  logic signed [DW-1:0] x_in,
    output logic                 run_n,
    output logic                 busy,
    output logic                 converged,
    output logic                 timeout,
    output logic                 seq_err,
    output logic [ITER_W-1:0]    iter_cnt,
    output logic signed [DW-1:0] x_out
);
    localparam int                SW    = $clog2(STABLE_N + 1);
    localparam logic [DW:0]       TOL_V = (DW+1)'(TOL);
    localparam logic [ITER_W-1:0] MAX_V = ITER_W'(MAX_ITER);
    localparam logic [SW-1:0]     STB_V = SW'(STABLE_N);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    // Difference is taken one bit wider so full-scale swings cannot wrap into a small value.
    function automatic logic within_tol(input logic signed [DW-1:0] a,
                                        input logic signed [DW-1:0] b);
        logic signed [DW:0] d;
        logic [DW:0]        mag;
        d   = {a[DW-1], a} - {b[DW-1], b};
        mag = d[DW] ? $unsigned(-d) : $unsigned(d);
        return mag <= TOL_V;
    endfunction

    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    state_t               state;
    logic                 samp_p1;
    logic                 first_smp;
    logic                 err_flag;
    logic signed [DW-1:0] x_prev;
    logic [SW-1:0]        stable_cnt;
    logic [SW-1:0]        stable_nxt;
    logic [ITER_W-1:0]    iter_nxt;
    logic                 seq_bad;
    logic                 en00_hit;

`ifdef NET_ITER_SEQCHK_EN
    logic [10:0] low;
    logic [3:0]  exp_stg;
    logic [3:0]  strobe_stg;
    logic [3:0]  last_stg;
    logic        seen_vld;
    logic        one_low;
    logic        multi_low;
    logic        advance;

    function automatic logic [3:0] stage_of(input logic [10:0] l);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 11; i++)
            if (l[i]) s = 4'(10 - i);
        return s;
    endfunction

    assign low        = ~en_bus;
    assign one_low    = (low != '0) && ((low & (low - 11'd1)) == '0);
    assign multi_low  = (low != '0) && !one_low;
    assign strobe_stg = stage_of(low);
    assign last_stg   = (exp_stg == 4'd0) ? 4'd10 : exp_stg - 4'd1;
    assign advance    = one_low && (strobe_stg == exp_stg);
    // Re-asserting the stage just seen is tolerated; anything else out of order is an error.
    assign seq_bad    = multi_low ||
                        (one_low && !advance && !(seen_vld && (strobe_stg == last_stg)));
    assign en00_hit   = one_low && (strobe_stg == 4'd0) && !seq_bad;
`else
    logic unused_stg;
    assign unused_stg = ^en_bus[9:0];
    assign seq_bad    = 1'b0;
    assign en00_hit   = !en_bus[10];
`endif

    assign iter_nxt   = sat_inc(iter_cnt);
    assign stable_nxt = (first_smp || !within_tol(x_in, x_prev)) ? '0 : stable_cnt + 1'b1;
    assign seq_err    = err_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            run_n      <= 1'b1;
            busy       <= 1'b0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
            err_flag   <= 1'b0;
            iter_cnt   <= '0;
            x_out      <= '0;
            x_prev     <= '0;
            stable_cnt <= '0;
            first_smp  <= 1'b0;
            samp_p1    <= 1'b0;
`ifdef NET_ITER_SEQCHK_EN
            exp_stg    <= '0;
            seen_vld   <= 1'b0;
`endif
        end else begin
            unique case (state)
                RUN: begin
                    if (seq_bad) begin
                        state    <= ERR;
                        err_flag <= 1'b1;
                        run_n    <= 1'b1;
                        busy     <= 1'b0;
                        samp_p1  <= 1'b0;
                    end else begin
                        // en00 seen this cycle: integrator output is sampled next cycle
                        samp_p1 <= en00_hit;
`ifdef NET_ITER_SEQCHK_EN
                        if (advance) begin
                            exp_stg  <= (exp_stg == 4'd10) ? 4'd0 : exp_stg + 4'd1;
                            seen_vld <= 1'b1;
                        end
`endif
                        if (samp_p1) begin
                            iter_cnt   <= iter_nxt;
                            x_prev     <= x_in;
                            x_out      <= x_in;
                            first_smp  <= 1'b0;
                            stable_cnt <= stable_nxt;
                            if (stable_nxt >= STB_V) begin
                                converged <= 1'b1;
                                state     <= DONE;
                                run_n     <= 1'b1;
                                busy      <= 1'b0;
                            end else if (iter_nxt >= MAX_V) begin
                                timeout <= 1'b1;
                                state   <= DONE;
                                run_n   <= 1'b1;
                                busy    <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state      <= RUN;
                        run_n      <= 1'b0;
                        busy       <= 1'b1;
                        converged  <= 1'b0;
                        timeout    <= 1'b0;
                        err_flag   <= 1'b0;
                        iter_cnt   <= '0;
                        stable_cnt <= '0;
                        first_smp  <= 1'b1;
                        samp_p1    <= 1'b0;
`ifdef NET_ITER_SEQCHK_EN
                        exp_stg    <= '0;
                        seen_vld   <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_net_iter_monitor.sv
// Bench for net_iter_monitor: two instances (MAX_ITER 1000 and 10) against a spec-level model,
// a table of directed solve runs, hand-written corner sequences and randomized runs.
module tb_net_iter_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset, start;
    logic [10:0]         en_bus;
    logic signed [15:0]  x_in;
    logic                run_n0, busy0, conv0, to0, err0;
    logic                run_n1, busy1, conv1, to1, err1;
    logic [15:0]         iter0, iter1;
    logic signed [15:0]  xout0, xout1;

    net_iter_monitor #(.DW(16), .ITER_W(16), .MAX_ITER(1000), .TOL(4), .STABLE_N(8)) dut0 (
        .clk(clk), .reset(reset), .start(start), .en_bus(en_bus), .x_in(x_in),
        .run_n(run_n0), .busy(busy0), .converged(conv0), .timeout(to0), .seq_err(err0),
        .iter_cnt(iter0), .x_out(xout0));

    net_iter_monitor #(.DW(16), .ITER_W(16), .MAX_ITER(10), .TOL(4), .STABLE_N(8)) dut1 (
        .clk(clk), .reset(reset), .start(start), .en_bus(en_bus), .x_in(x_in),
        .run_n(run_n1), .busy(busy1), .converged(conv1), .timeout(to1), .seq_err(err1),
        .iter_cnt(iter1), .x_out(xout1));

    // st: 0 idle, 1 running, 2 done, 3 error
    typedef struct {
        int st; bit conv; bit to; bit err; int iter; int xout; int prev;
        bit first; int stable; bit pend; int nexp; int last;
    } model_t;

    typedef struct {
        int kind; int n;
        bit c0; bit t0; bit b0; int i0; int x0;
        bit c1; bit t1; bit b1; int i1; int x1;
    } vec_t;

    model_t m[2];
    int     checks = 0;
    int     failures = 0;
    int     xv;

    function automatic model_t mreset();
        model_t r;
        r = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
        return r;
    endfunction

    function automatic model_t mstep(model_t mm, int max_iter, bit st, logic [10:0] en, int x);
        model_t r;
        int lows, stg, d;
        bit bad, np;
        r = mm; lows = 0; stg = -1; bad = 0; np = 0;
        if (r.st != 1) begin
            if (st) begin
                r.st = 1; r.conv = 0; r.to = 0; r.err = 0; r.iter = 0; r.stable = 0;
                r.first = 1; r.pend = 0; r.nexp = 0; r.last = -1;
            end
            return r;
        end
        for (int b = 0; b < 11; b++)
            if (!en[b]) begin lows++; stg = 10 - b; end
`ifdef NET_ITER_SEQCHK_EN
        if (lows > 1) bad = 1;
        else if (lows == 1) begin
            if (stg == r.nexp) begin r.last = stg; r.nexp = (stg + 1) % 11; end
            else if (stg != r.last) bad = 1;
        end
        np = (lows == 1) && (stg == 0) && !bad;
`else
        np = !en[10];
`endif
        if (bad) begin r.st = 3; r.err = 1; r.pend = 0; return r; end
        if (r.pend) begin
            r.iter = (r.iter < 65535) ? r.iter + 1 : 65535;
            d = x - r.prev;
            if (d < 0) d = -d;
            if (r.first) r.stable = 0;
            else if (d <= 4) r.stable = r.stable + 1;
            else r.stable = 0;
            r.first = 0; r.prev = x; r.xout = x;
            if (r.stable >= 8) begin r.conv = 1; r.st = 2; end
            else if (r.iter >= max_iter) begin r.to = 1; r.st = 2; end
        end
        r.pend = np;
        return r;
    endfunction

    function automatic logic [10:0] strobe(int s);
        logic [10:0] r;
        r = '1;
        r[10 - s] = 1'b0;
        return r;
    endfunction

    function automatic int kval(int kind, int k);
        case (kind)
            0: case ((k - 1) % 4)
                   0: return 100;
                   1: return 103;
                   2: return 101;
                   default: return 102;
               endcase
            1: return (k < 4) ? 200 : 205;
            2: return (k % 2 == 1) ? 0 : 50;
            3: return (k % 2 == 1) ? 0 : 4;
            4: return (k % 2 == 1) ? -32768 : 32767;
            default: return (k % 2 == 1) ? 0 : 5;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_dut(input string p, input logic rn, input logic bz, input logic cv,
                           input logic tt, input logic er, input logic [15:0] it,
                           input logic signed [15:0] xo, input model_t mm);
        chk({p, ".run_n"},     int'(rn), int'(mm.st != 1));
        chk({p, ".busy"},      int'(bz), int'(mm.st == 1));
        chk({p, ".converged"}, int'(cv), int'(mm.conv));
        chk({p, ".timeout"},   int'(tt), int'(mm.to));
        chk({p, ".seq_err"},   int'(er), int'(mm.err));
        chk({p, ".iter_cnt"},  int'(it), mm.iter);
        chk({p, ".x_out"},     int'(xo), mm.xout);
    endtask

    task automatic chk_all();
        chk_dut("m0", run_n0, busy0, conv0, to0, err0, iter0, xout0, m[0]);
        chk_dut("m1", run_n1, busy1, conv1, to1, err1, iter1, xout1, m[1]);
    endtask

    // One clock: drive at the falling edge, model advances on the rising edge, compare at the next fall.
    task automatic cyc(input bit st, input logic [10:0] en, input int x);
        logic [31:0] xb;
        xb = x;
        start = st; en_bus = en; xv = x; x_in = xb[15:0];
        @(posedge clk);
        if (!reset) begin
            m[0] = mreset(); m[1] = mreset();
        end else begin
            m[0] = mstep(m[0], 1000, start, en_bus, xv);
            m[1] = mstep(m[1], 10, start, en_bus, xv);
        end
        @(negedge clk);
        start = 1'b0;
        chk_all();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        m[0] = mreset(); m[1] = mreset();
        chk_all();
        cyc(1'b0, 11'h7FF, 0);
        reset = 1'b1;
    endtask

    task automatic iter_seq(input int x, input int gmin, input int gmax, input bit rep);
        int g;
        for (int s = 0; s < 11; s++) begin
            cyc(1'b0, strobe(s), x);
            if (rep && s != 0 && $urandom_range(3) == 0) cyc(1'b0, strobe(s), x);
            g = int'($urandom_range(gmax, gmin));
            for (int i = 0; i < g; i++) cyc(1'b0, 11'h7FF, x);
        end
    endtask

    vec_t vt[6];
    int   x;

    initial begin
        vt[0] = '{0,  9, 1, 0, 0,  9,   100, 1, 0, 0,  9,   100};
        vt[1] = '{1, 14, 1, 0, 0, 12,   205, 0, 1, 0, 10,   205};
        vt[2] = '{2, 12, 0, 0, 1, 12,    50, 0, 1, 0, 10,    50};
        vt[3] = '{3,  9, 1, 0, 0,  9,     0, 1, 0, 0,  9,     0};
        vt[4] = '{4, 12, 0, 0, 1, 12, 32767, 0, 1, 0, 10, 32767};
        vt[5] = '{5, 10, 0, 0, 1, 10,     5, 0, 1, 0, 10,     5};

        reset = 1'b0; start = 1'b0; en_bus = '1; x_in = '0; xv = 0;
        m[0] = mreset(); m[1] = mreset();
        @(negedge clk);
        chk("rst.run_n", int'(run_n0), 1);
        chk("rst.busy", int'(busy0), 0);
        chk("rst.iter_cnt", int'(iter0), 0);
        chk("rst.x_out", int'(xout0), 0);
        chk_all();
        reset = 1'b1;

        // directed solve runs
        for (int v = 0; v < 6; v++) begin
            pulse_reset();
            cyc(1'b1, 11'h7FF, 0);
            for (int k = 1; k <= vt[v].n; k++) iter_seq(kval(vt[v].kind, k), 1, 1, 1'b0);
            chk($sformatf("vec%0d.m0.converged", v), int'(conv0), int'(vt[v].c0));
            chk($sformatf("vec%0d.m0.timeout", v),   int'(to0),   int'(vt[v].t0));
            chk($sformatf("vec%0d.m0.busy", v),      int'(busy0), int'(vt[v].b0));
            chk($sformatf("vec%0d.m0.iter_cnt", v),  int'(iter0), vt[v].i0);
            chk($sformatf("vec%0d.m0.x_out", v),     int'(xout0), vt[v].x0);
            chk($sformatf("vec%0d.m1.converged", v), int'(conv1), int'(vt[v].c1));
            chk($sformatf("vec%0d.m1.timeout", v),   int'(to1),   int'(vt[v].t1));
            chk($sformatf("vec%0d.m1.busy", v),      int'(busy1), int'(vt[v].b1));
            chk($sformatf("vec%0d.m1.iter_cnt", v),  int'(iter1), vt[v].i1);
            chk($sformatf("vec%0d.m1.x_out", v),     int'(xout1), vt[v].x1);
        end

        // reset mid-run with five completed iterations
        pulse_reset();
        cyc(1'b1, 11'h7FF, 0);
        for (int k = 0; k < 5; k++) iter_seq(7, 1, 1, 1'b0);
        chk("midrst.pre_iter", int'(iter0), 5);
        cyc(1'b0, strobe(0), 7);
        reset = 1'b0;
        #1;
        chk("midrst.run_n", int'(run_n0), 1);
        chk("midrst.busy", int'(busy0), 0);
        chk("midrst.iter_cnt", int'(iter0), 0);
        chk("midrst.flags", int'({conv0, to0, err0}), 0);
        chk("midrst.x_out", int'(xout0), 0);
        m[0] = mreset(); m[1] = mreset();
        chk_all();
        cyc(1'b0, 11'h7FF, 7);
        reset = 1'b1;

        // start while running is ignored
        cyc(1'b1, 11'h7FF, 0);
        for (int k = 0; k < 3; k++) iter_seq(9, 1, 1, 1'b0);
        cyc(1'b1, 11'h7FF, 9);
        chk("ign_start.iter_cnt", int'(iter0), 3);
        chk("ign_start.busy", int'(busy0), 1);

`ifdef NET_ITER_SEQCHK_EN
        pulse_reset();
        cyc(1'b1, 11'h7FF, 0);
        cyc(1'b0, strobe(0), 10);
        cyc(1'b0, 11'h7FF, 10);
        cyc(1'b0, strobe(2), 10);
        chk("order.seq_err", int'(err0), 1);
        chk("order.run_n", int'(run_n0), 1);
        chk("order.busy", int'(busy0), 0);
        chk("order.x_out", int'(xout0), 10);
        cyc(1'b1, 11'h7FF, 0);
        chk("restart.seq_err", int'(err0), 0);
        chk("restart.busy", int'(busy0), 1);
        cyc(1'b0, strobe(0), 20);
        cyc(1'b0, 11'h7FF, 20);
        cyc(1'b0, strobe(1), 20);
        cyc(1'b0, strobe(1), 20);
        cyc(1'b0, strobe(2), 20);
        chk("repeat.seq_err", int'(err0), 0);
        chk("repeat.busy", int'(busy0), 1);
        pulse_reset();
        cyc(1'b1, 11'h7FF, 0);
        cyc(1'b0, strobe(0) & strobe(5), 30);
        chk("multi.seq_err", int'(err0), 1);
        chk("multi.busy", int'(busy0), 0);
`else
        pulse_reset();
        cyc(1'b1, 11'h7FF, 0);
        cyc(1'b0, strobe(0) & strobe(5), 30);
        cyc(1'b0, 11'h7FF, 30);
        chk("multi.iter_cnt", int'(iter0), 1);
        chk("multi.seq_err", int'(err0), 0);
        chk("multi.x_out", int'(xout0), 30);
`endif

        // randomized runs against the model
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(2) == 0) pulse_reset();
            x = int'($urandom_range(2000)) - 1000;
            cyc(1'b1, 11'h7FF, x);
            for (int k = 0; k < int'($urandom_range(16, 1)); k++) begin
                if ($urandom_range(5) == 0) x = int'($urandom_range(65535)) - 32768;
                else x = x + int'($urandom_range(10)) - 5;
                if (x > 32767) x = 32767;
                if (x < -32768) x = -32768;
                if ($urandom_range(15) == 0) cyc(1'b0, 11'($urandom), x);
                if ($urandom_range(19) == 0) cyc(1'b1, 11'h7FF, x);
                iter_seq(x, 0, 2, 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
